mem_stage_lsu: RTL and testbench

Parametrised MIPS memory-access pipeline stage sitting between EXE and WB.
- Replaces the plain MEM pipeline register with a single-entry skid stage that performs LB/LBU/LH/LHU/LW/SB/SH/SW on a wait-state data bus.
- Applies byte-lane alignment, sign/zero extension and address-error detection.
- Handshakes with EXE and WB through valid/ready, and supports pipeline flush.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_lsu_align.sv | 97 +++++++++
 rtl/mem_stage_lsu.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage load/store unit.
//   mem_op_e : memory operation codes carried on in_op
//   exc_e    : exception codes reported on out_exc
//   state_e  : MEM stage FSM states
package mem_stage_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LBU  = 4'd2,
    LH   = 4'd3,
    LHU  = 4'd4,
    LW   = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic for the MEM stage.
//   op, addr_lo      : operation and low address bits
//   store_data       : rt value to be formatted for the bus
//   rdata            : raw bus read word
//   is_load/is_store : operation class
//   misalign         : access not naturally aligned
//   be, wdata        : byte enables and lane-replicated store data
//   load_val         : extracted and extended load result (little-endian)
module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  mem_op_e    op_e;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign op_e = mem_op_e'(op);

  always_comb begin
    unique case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    be       = '0;
    wdata    = '0;
    load_val = '0;
    case (op_e)
      LB: begin
        is_load  = 1'b1;
        be       = 4'b0001 << addr_lo;
        load_val = {{24{rbyte[7]}}, rbyte};
      end
      LBU: begin
        is_load  = 1'b1;
        be       = 4'b0001 << addr_lo;
        load_val = {24'd0, rbyte};
      end
      LH: begin
        is_load  = 1'b1;
        misalign = addr_lo[0];
        be       = addr_lo[1] ? BE_HI : BE_LO;
        load_val = {{16{rhalf[15]}}, rhalf};
      end
      LHU: begin
        is_load  = 1'b1;
        misalign = addr_lo[0];
        be       = addr_lo[1] ? BE_HI : BE_LO;
        load_val = {16'd0, rhalf};
      end
      LW: begin
        is_load  = 1'b1;
        misalign = (addr_lo != 2'd0);
        be       = BE_WORD;
        load_val = rdata;
      end
      SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
      end
      SH: begin
        is_store = 1'b1;
        misalign = addr_lo[0];
        be       = addr_lo[1] ? BE_HI : BE_LO;
        wdata    = {2{store_data[15:0]}};
      end
      SW: begin
        is_store = 1'b1;
        misalign = (addr_lo != 2'd0);
        be       = BE_WORD;
        wdata    = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM pipeline stage: single-entry skid stage performing loads/stores
// on a wait-state data bus, with alignment checks and valid/ready handshakes.
//   clk, rstn         : clock, asynchronous active-low reset
//   flush             : kill held/incoming instruction
//   in_*              : instruction from EXE (valid/ready handshake)
//   dreq..drdata      : data bus (request held until dack)
//   out_*             : result to WB (valid/ready handshake)
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_store_data,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic              in_we,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic              dreq,
  output logic              dwe,
  output logic [3:0]        dbe,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dwdata,
  input  logic              dack,
  input  logic [31:0]       drdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_we,
  output logic [1:0]        out_exc,
  output logic [ADDR_W-1:0] out_badvaddr,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       out_inst
);

  state_e      state, state_nx;
  logic [3:0]  h_op;
  logic [1:0]  h_lo;
  logic [3:0]  a_op;
  logic [1:0]  a_lo;
  logic        is_load, is_store, misalign;
  logic [3:0]  be;
  logic [31:0] wdata, load_val;
  logic        accept, start_bus, bus_done, deliver;

  // One aligner serves both ends: in IDLE it formats the incoming access,
  // while a request is outstanding it decodes the held op for load extraction.
  assign a_op = (state == ST_IDLE) ? in_op : h_op;
  assign a_lo = (state == ST_IDLE) ? in_addr[1:0] : h_lo;

  lsu_align u_align (
    .op         (a_op),
    .addr_lo    (a_lo),
    .store_data (in_store_data),
    .rdata      (drdata),
    .is_load    (is_load),
    .is_store   (is_store),
    .misalign   (misalign),
    .be         (be),
    .wdata      (wdata),
    .load_val   (load_val)
  );

  assign bus_done = dreq && dack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    deliver   = 1'b0;
    in_ready  = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
    accept    = in_valid && in_ready;
    start_bus = accept && (is_load || is_store) && !misalign;
    case (state)
      ST_IDLE: if (start_bus) state_nx = ST_BUS;
      ST_BUS: begin
        if (bus_done) begin
          state_nx = ST_IDLE;
          deliver  = !flush;
        end else if (flush) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: if (bus_done) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The output registers double as the single held entry: sideband fields
  // load at accept, which is safe because accept implies the old entry drains.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_wreg     <= '0;
      out_we       <= 1'b0;
      out_exc      <= EXC_NONE;
      out_badvaddr <= '0;
      out_pc       <= '0;
      out_inst     <= '0;
      h_op         <= '0;
      h_lo         <= '0;
    end else begin
      if (accept) begin
        out_result <= in_result;
        out_wreg   <= in_wreg;
        out_pc     <= in_pc;
        out_inst   <= in_inst;
        h_op       <= in_op;
        h_lo       <= in_addr[1:0];
        if (misalign) begin
          out_exc      <= is_load ? EXC_ADEL : EXC_ADES;
          out_badvaddr <= in_addr;
          out_we       <= 1'b0;
        end else begin
          out_exc      <= EXC_NONE;
          out_badvaddr <= '0;
          out_we       <= in_we && !is_store;
        end
      end
      if (deliver && is_load) out_result <= load_val;

      if (accept)                    out_valid <= !start_bus;
      else if (deliver)              out_valid <= 1'b1;
      else if (flush || out_ready)   out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dreq   <= 1'b0;
      dwe    <= 1'b0;
      dbe    <= '0;
      daddr  <= '0;
      dwdata <= '0;
    end else if (start_bus) begin
      dreq   <= 1'b1;
      dwe    <= is_store;
      dbe    <= be;
      daddr  <= {in_addr[ADDR_W-1:2], 2'b00};
      dwdata <= wdata;
    end else if (bus_done) begin
      dreq   <= 1'b0;
      dwe    <= 1'b0;
      dbe    <= '0;
      daddr  <= '0;
      dwdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr, in_result, in_store_data;
  logic [4:0]  in_wreg;
  logic        in_we;
  logic [31:0] in_pc, in_inst;
  logic        dreq, dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr, dwdata;
  logic        dack;
  logic [31:0] drdata;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_wreg;
  logic        out_we;
  logic [1:0]  out_exc;
  logic [31:0] out_badvaddr, out_pc, out_inst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .REG_W(5), .PC_W(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_result(in_result), .in_store_data(in_store_data), .in_wreg(in_wreg),
    .in_we(in_we), .in_pc(in_pc), .in_inst(in_inst),
    .dreq(dreq), .dwe(dwe), .dbe(dbe), .daddr(daddr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_wreg(out_wreg), .out_we(out_we), .out_exc(out_exc),
    .out_badvaddr(out_badvaddr), .out_pc(out_pc), .out_inst(out_inst)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, res, sd);
    in_valid      = 1'b1;
    in_op         = op;
    in_addr       = addr;
    in_result     = res;
    in_store_data = sd;
    in_we         = 1'b1;
    in_wreg       = 5'd7;
    in_pc         = 32'hBFC0_0100;
    in_inst       = 32'h8C00_0000;
  endtask

  // Accepts one memory op, waits 'waits' cycles, then acks with rdata.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, res, sd, rdata,
                           input int waits, output int nreq, output logic [31:0] c_addr,
                           output logic [3:0] c_be, output logic [31:0] c_wdata,
                           output logic c_we);
    drive(op, addr, res, sd);
    tick();
    in_valid = 1'b0;
    nreq     = 0;
    c_addr   = daddr;
    c_be     = dbe;
    c_wdata  = dwdata;
    c_we     = dwe;
    check("bus_in_ready_low", in_ready, 0);
    for (int i = 0; i < waits; i++) begin
      if (dreq) nreq++;
      tick();
    end
    if (dreq) nreq++;
    dack   = 1'b1;
    drdata = rdata;
    tick();
    dack = 1'b0;
  endtask

  task automatic do_misaligned(input logic [3:0] op, input logic [31:0] addr,
                               input logic [1:0] exc);
    drive(op, addr, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("mis_valid", out_valid, 1);
    check("mis_dreq", dreq, 0);
    check("mis_exc", out_exc, exc);
    check("mis_badvaddr", out_badvaddr, addr);
    check("mis_we", out_we, 0);
    tick();
  endtask

  initial begin
    int          nreq;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = '0;
    in_result = '0; in_store_data = '0; in_wreg = '0; in_we = 1'b0;
    in_pc = '0; in_inst = '0; dack = 1'b0; drdata = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_dreq", dreq, 0);
    check("rst_out_result", out_result, 0);
    check("rst_daddr", daddr, 0);
    check("rst_dbe", dbe, 0);
    check("rst_out_exc", out_exc, 0);
    rstn = 1'b1;
    tick();

    // Non-memory op: one-cycle latency, no bus traffic
    drive(4'd0, 32'h0, 32'h1234_5678, 32'h0);
    check("none_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("none_valid", out_valid, 1);
    check("none_result", out_result, 32'h1234_5678);
    check("none_we", out_we, 1);
    check("none_pc", out_pc, 32'hBFC0_0100);
    check("none_dreq", dreq, 0);
    tick();
    check("none_drained", out_valid, 0);

    // Four back-to-back ops
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 32'h0, 32'hA0 + i, 32'h0);
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_result", out_result, 32'hA0 + i);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_end", out_valid, 0);

    // Stray dack with no request
    dack = 1'b1;
    tick();
    dack = 1'b0;
    check("stray_dack", out_valid, 0);

    // LB with three wait states
    do_access(4'd1, 32'h1003, 32'h0, 32'h0, 32'h80FF_0000, 3, nreq, c_addr, c_be, c_wdata, c_we);
    check("lb_nreq", nreq, 4);
    check("lb_daddr", c_addr, 32'h1000);
    check("lb_dbe", c_be, 4'b1000);
    check("lb_dwe", c_we, 0);
    check("lb_valid", out_valid, 1);
    check("lb_result", out_result, 32'hFFFF_FF80);
    check("lb_we", out_we, 1);
    check("lb_dreq_done", dreq, 0);
    tick();

    do_access(4'd2, 32'h1003, 32'h0, 32'h0, 32'h80FF_0000, 0, nreq, c_addr, c_be, c_wdata, c_we);
    check("lbu_nreq", nreq, 1);
    check("lbu_result", out_result, 32'h0000_0080);
    tick();

    do_access(4'd3, 32'h1002, 32'h0, 32'h0, 32'h80FF_0000, 1, nreq, c_addr, c_be, c_wdata, c_we);
    check("lh_dbe", c_be, 4'b1100);
    check("lh_result", out_result, 32'hFFFF_80FF);
    tick();

    do_access(4'd4, 32'h1000, 32'h0, 32'h0, 32'h1234_8001, 1, nreq, c_addr, c_be, c_wdata, c_we);
    check("lhu_dbe", c_be, 4'b0011);
    check("lhu_result", out_result, 32'h0000_8001);
    tick();

    do_access(4'd5, 32'h1004, 32'h0, 32'h0, 32'hDEAD_BEEF, 2, nreq, c_addr, c_be, c_wdata, c_we);
    check("lw_nreq", nreq, 3);
    check("lw_daddr", c_addr, 32'h1004);
    check("lw_dbe", c_be, 4'b1111);
    check("lw_result", out_result, 32'hDEAD_BEEF);
    tick();

    do_access(4'd7, 32'h2002, 32'h1111_2222, 32'h0000_BEEF, 32'h0, 1, nreq, c_addr, c_be, c_wdata, c_we);
    check("sh_dwe", c_we, 1);
    check("sh_dbe", c_be, 4'b1100);
    check("sh_dwdata", c_wdata, 32'hBEEF_BEEF);
    check("sh_daddr", c_addr, 32'h2000);
    check("sh_valid", out_valid, 1);
    check("sh_we", out_we, 0);
    check("sh_result", out_result, 32'h1111_2222);
    tick();

    do_access(4'd6, 32'h2001, 32'h0, 32'h1234_565A, 32'h0, 0, nreq, c_addr, c_be, c_wdata, c_we);
    check("sb_dbe", c_be, 4'b0010);
    check("sb_dwdata", c_wdata, 32'h5A5A_5A5A);
    check("sb_exc", out_exc, 0);
    tick();

    // Address errors
    do_misaligned(4'd5, 32'h3001, 2'b01);
    do_misaligned(4'd8, 32'h3002, 2'b10);
    do_misaligned(4'd4, 32'h3003, 2'b01);
    do_misaligned(4'd7, 32'h3005, 2'b10);

    // Flush while a load is outstanding
    drive(4'd5, 32'h4000, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("fl_dreq1", dreq, 1);
    tick();
    flush = 1'b1;
    check("fl_in_ready_flush", in_ready, 0);
    tick();
    flush = 1'b0;
    check("fl_drain_dreq", dreq, 1);
    check("fl_drain_ready", in_ready, 0);
    check("fl_drain_valid", out_valid, 0);
    tick();
    check("fl_drain_dreq2", dreq, 1);
    dack   = 1'b1;
    drdata = 32'hCAFE_F00D;
    tick();
    dack = 1'b0;
    check("fl_done_valid", out_valid, 0);
    check("fl_done_dreq", dreq, 0);
    check("fl_done_ready", in_ready, 1);
    tick();
    check("fl_after_valid", out_valid, 0);

    // Back-pressure from WB, then flush in IDLE
    out_ready = 1'b0;
    drive(4'd0, 32'h0, 32'h55, 32'h0);
    tick();
    check("bp_valid", out_valid, 1);
    drive(4'd0, 32'h0, 32'h66, 32'h0);
    #0;
    check("bp_in_ready", in_ready, 0);
    tick();
    tick();
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_result", out_result, 32'h55);
    in_valid = 1'b0;
    flush    = 1'b1;
    #0;
    check("bp_flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("bp_flush_valid", out_valid, 0);
    out_ready = 1'b1;

    // Asynchronous reset in the middle of a bus transaction
    drive(4'd5, 32'h5000, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("ar_dreq", dreq, 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_dreq_clr", dreq, 0);
    check("ar_daddr_clr", daddr, 0);
    check("ar_dbe_clr", dbe, 0);
    check("ar_valid_clr", out_valid, 0);
    check("ar_pc_clr", out_pc, 0);
    #2 rstn = 1'b1;
    tick();
    check("ar_idle_ready", in_ready, 1);
    check("ar_idle_dreq", dreq, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
